// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the data width, fetch FSM states and the default boot address.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_t;

    // Sequential fetch address; wraps from 32'hFFFF_FFFC to zero.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} pairs with push, pop and flush.
// Flush wins over push and pop; pointers wrap modulo DEPTH.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    input  logic            i_pop,
    output logic [AW:0]     o_count,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr
);

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [XLEN-1:0] r_instr [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && (r_count != '0) && !i_flush;
    assign o_count = r_count;
    assign o_pc    = r_pc[r_rptr];
    assign o_instr = r_instr[r_rptr];

    // Entry storage; only the slot under the write pointer changes.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc[r_wptr]    <= i_pc;
            r_instr[r_wptr] <= i_instr;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: one outstanding memory request,
// a small prefetch queue, and redirect handling with stale-response discard.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPc,
    input  logic        instrReady
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;

    logic [AW:0]  w_count;
    logic         w_issue;
    logic         w_accept;
    logic         w_pop;
    logic         w_unused_bits;

    // Low address bits of a redirect target are forced to word alignment.
    assign w_unused_bits = ^redirectPc[1:0];

    // A request is only issued when a queue slot is free for its response.
    assign w_issue  = !reset && (r_state == IDLE)
                   && (w_count < DEPTH_C) && !redirect;
    assign w_accept = (r_state == WAIT) && memRvalid && !redirect;
    assign w_pop    = instrValid && instrReady;

    assign memReq     = w_issue;
    assign memAddr    = r_fetch_pc;
    assign instrValid = !reset && (w_count != '0);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (redirect),
        .i_push  (w_accept),
        .i_pc    (r_fetch_pc),
        .i_instr (memRdata),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_pc    (instrPc),
        .o_instr (instr)
    );

    // Fetch FSM and fetch address; responses after a redirect are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            if (redirect) begin
                r_fetch_pc <= {redirectPc[31:2], 2'b00};
            end else if (w_accept) begin
                r_fetch_pc <= next_pc(r_fetch_pc);
            end
            unique case (r_state)
                IDLE: begin
                    if (w_issue) r_state <= WAIT;
                end
                WAIT: begin
                    if (memRvalid)     r_state <= IDLE;
                    else if (redirect) r_state <= DISCARD;
                end
                DISCARD: begin
                    if (memRvalid) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table for streaming
// and back-pressure, plus hand-written redirect, wrap and reset sequences.
module tb_instr_fetch;

    localparam logic [31:0] K = 32'h5A5A_C3C3;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrReady;

    int checks   = 0;
    int failures = 0;

    bit          mem_auto;
    bit          pend;
    logic [31:0] paddr;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memRvalid  (memRvalid),
        .memRdata   (memRdata),
        .instrValid (instrValid),
        .instr      (instr),
        .instrPc    (instrPc),
        .instrReady (instrReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rq;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic rdy,
                               input logic rq, input logic [31:0] addr,
                               input logic iv, input logic [31:0] pc);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.rq = rq;
        t.addr = addr; t.iv = iv; t.pc = pc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs for the current cycle and let them settle.
    task automatic drive(input logic rst, input logic rdy, input logic rdr,
                         input logic [31:0] rpc, input logic rv,
                         input logic [31:0] rd);
        reset      = rst;
        instrReady = rdy;
        redirect   = rdr;
        redirectPc = rpc;
        if (mem_auto) begin
            memRvalid = pend;
            memRdata  = paddr ^ K;
            pend      = 1'b0;
        end else begin
            memRvalid = rv;
            memRdata  = rd;
        end
        #1;
    endtask

    // One-cycle memory model records the request, then advance a cycle.
    task automatic adv();
        if (mem_auto && memReq === 1'b1) begin
            pend  = 1'b1;
            paddr = memAddr;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[26];

    initial begin
        reset = 1'b1; redirect = 1'b0; redirectPc = '0;
        memRvalid = 1'b0; memRdata = '0; instrReady = 1'b0;
        mem_auto = 1'b1; pend = 1'b0; paddr = '0;

        // Streaming with ready=1, then a reset and 10 cycles of back-pressure.
        tbl[0]  = v(1, 1, 0, 0, 0, 0);
        tbl[1]  = v(1, 1, 0, 0, 0, 0);
        tbl[2]  = v(0, 1, 1, 32'h0, 0, 0);
        tbl[3]  = v(0, 1, 0, 0, 0, 0);
        tbl[4]  = v(0, 1, 1, 32'h4, 1, 32'h0);
        tbl[5]  = v(0, 1, 0, 0, 0, 0);
        tbl[6]  = v(0, 1, 1, 32'h8, 1, 32'h4);
        tbl[7]  = v(0, 1, 0, 0, 0, 0);
        tbl[8]  = v(0, 1, 1, 32'hC, 1, 32'h8);
        tbl[9]  = v(0, 1, 0, 0, 0, 0);
        tbl[10] = v(1, 0, 0, 0, 0, 0);
        tbl[11] = v(0, 0, 1, 32'h0, 0, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0);
        tbl[13] = v(0, 0, 1, 32'h4, 1, 32'h0);
        tbl[14] = v(0, 0, 0, 0, 1, 32'h0);
        for (int i = 15; i <= 20; i++) tbl[i] = v(0, 0, 0, 0, 1, 32'h0);
        tbl[21] = v(0, 1, 0, 0, 1, 32'h0);
        tbl[22] = v(0, 1, 1, 32'h8, 1, 32'h4);
        tbl[23] = v(0, 1, 0, 0, 0, 0);
        tbl[24] = v(0, 1, 1, 32'hC, 1, 32'h8);
        tbl[25] = v(0, 1, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, 1'b0, '0, 1'b0, '0);
            chk($sformatf("v%0d_memReq", i), memReq, tbl[i].rq);
            if (tbl[i].rq) chk($sformatf("v%0d_memAddr", i), memAddr, tbl[i].addr);
            chk($sformatf("v%0d_instrValid", i), instrValid, tbl[i].iv);
            if (tbl[i].iv) begin
                chk($sformatf("v%0d_instrPc", i), instrPc, tbl[i].pc);
                chk($sformatf("v%0d_instr", i), instr, tbl[i].pc ^ K);
            end
            adv();
        end

        mem_auto = 1'b0;
        pend     = 1'b0;

        // Redirect while waiting; late response dropped in DISCARD.
        drive(1, 1, 0, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s25_req0", memReq, 1); chk("s25_addr0", memAddr, 0); adv();
        drive(0, 1, 1, 32'h0000_0103, 0, 0);
        chk("s25_redir_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s25_disc_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 1, 32'h0 ^ K);
        chk("s25_drop_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s25_empty", instrValid, 0);
        chk("s25_req", memReq, 1);
        chk("s25_addr", memAddr, 32'h0000_0100); adv();

        // Redirect in the response cycle; then handshake during a redirect.
        drive(1, 1, 0, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s26_req0", memReq, 1); adv();
        drive(0, 1, 1, 32'h0000_0200, 1, K);
        chk("s26_redir_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s26_nopush", instrValid, 0);
        chk("s26_req", memReq, 1);
        chk("s26_addr", memAddr, 32'h0000_0200); adv();
        drive(0, 1, 0, 0, 1, 32'h0000_0200 ^ K); adv();
        drive(0, 1, 1, 32'h0000_0300, 0, 0);
        chk("s12_valid", instrValid, 1);
        chk("s12_pc", instrPc, 32'h0000_0200);
        chk("s12_instr", instr, 32'h0000_0200 ^ K);
        chk("s12_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s12_flushed", instrValid, 0);
        chk("s12_req", memReq, 1);
        chk("s12_addr", memAddr, 32'h0000_0300); adv();

        // Address wrap at the top of the address space.
        drive(1, 1, 0, 0, 0, 0); adv();
        drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        chk("s27_redir_noreq", memReq, 0); adv();
        drive(0, 0, 0, 0, 0, 0);
        chk("s27_req", memReq, 1);
        chk("s27_addr", memAddr, 32'hFFFF_FFFC); adv();
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC ^ K); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s27_valid", instrValid, 1);
        chk("s27_pc", instrPc, 32'hFFFF_FFFC);
        chk("s27_instr", instr, 32'hFFFF_FFFC ^ K);
        chk("s27_wrap_req", memReq, 1);
        chk("s27_wrap_addr", memAddr, 32'h0); adv();

        // Redirect while already discarding retargets the fetch.
        drive(0, 1, 1, 32'h0000_0500, 0, 0);
        chk("s14_popped", instrValid, 0);
        chk("s14_noreq0", memReq, 0); adv();
        drive(0, 1, 1, 32'h0000_0600, 0, 0);
        chk("s14_noreq1", memReq, 0); adv();
        drive(0, 1, 0, 0, 1, 32'hDEAD_0000);
        chk("s14_noreq2", memReq, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s14_nopush", instrValid, 0);
        chk("s14_req", memReq, 1);
        chk("s14_addr", memAddr, 32'h0000_0600); adv();

        // Reset while waiting; stale response in reset and IDLE ignored.
        drive(1, 1, 0, 0, 0, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s28_req0", memReq, 1); adv();
        drive(1, 1, 0, 0, 0, 0);
        chk("s28_rst_noreq", memReq, 0);
        chk("s28_rst_novalid", instrValid, 0); adv();
        drive(1, 1, 0, 0, 1, 32'h1234_5678);
        chk("s28_rst2_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 1, 32'h1234_5678);
        chk("s28_req", memReq, 1);
        chk("s28_addr", memAddr, 32'h0);
        chk("s28_novalid0", instrValid, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s28_novalid1", instrValid, 0);
        chk("s28_wait_noreq", memReq, 0); adv();
        drive(0, 1, 0, 0, 1, 32'h0 ^ K);
        chk("s28_novalid2", instrValid, 0); adv();
        drive(0, 1, 0, 0, 0, 0);
        chk("s28_valid", instrValid, 1);
        chk("s28_pc", instrPc, 32'h0);
        chk("s28_instr", instr, K); adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
